// File: rtl/rom_sequencer.sv
// Instruction sequencer for the program ROM: fetches, executes ADDI/ADD/NOP/OUT
// against a local 16x32 register file and presents OUT results on a valid/ready port.
module rom_sequencer #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              halted
);

  localparam int unsigned NREGS = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    OUT_WAIT,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADDI = 4'h1,
    OP_ADD  = 4'h2,
    OP_OUT  = 4'hF
  } opcode_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0]        op;
  logic [3:0]        rd;
  logic [3:0]        rs;
  logic [DATA_W-1:0] imm;
  logic              last_pc;

  always_comb begin
    op      = ir[31:28];
    rd      = ir[27:24];
    rs      = ir[23:20];
    imm     = '0;
    imm[23:0] = ir[23:0];
    last_pc = (pc == '1);
  end

  assign rom_addr = pc;

  // busy/halted are registered alongside the state so no output depends
  // combinationally on any input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
            pc     <= '0;
            state  <= FETCH;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end

        FETCH: begin
          ir    <= rom_data;
          state <= EXEC;
        end

        EXEC: begin
          if (op == OP_OUT) begin
            out_data  <= regs[rd];
            out_valid <= 1'b1;
            state     <= OUT_WAIT;
          end else begin
            case (op)
              OP_ADDI: regs[rd] <= regs[rd] + imm;
              OP_ADD:  regs[rd] <= regs[rd] + regs[rs];
              default: ;
            endcase
            if (last_pc) begin
              state  <= DONE;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end
        end

        OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_pc) begin
              state  <= DONE;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// Scoreboard bench for rom_sequencer: directed programs, expected OUT values queued
// by the stimulus and checked by independent monitors on the falling clock edge.
module tb_rom_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        halted;

  logic        start2;
  logic [3:0]  rom_addr2;
  logic [31:0] rom_data2;
  logic [31:0] out_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic        busy2;
  logic        halted2;

  logic [31:0] rom1 [8];
  logic [31:0] rom2 [16];

  logic [31:0] q  [$];
  logic [31:0] q2 [$];
  int          checks;
  int          errors;

  assign rom_data  = rom1[rom_addr];
  assign rom_data2 = rom2[rom_addr2];

  rom_sequencer #(.ADDR_W(3), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .halted    (halted)
  );

  // 16-entry variant: long enough to reach 0xFFFFFFFF and wrap it with ADDI.
  rom_sequencer #(.ADDR_W(4), .DATA_W(32)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .rom_addr  (rom_addr2),
    .rom_data  (rom_data2),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .busy      (busy2),
    .halted    (halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_data: unexpected output %h, none expected", out_data);
      end else begin
        if (out_data !== q[0]) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", out_data, q[0]);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL out_data2: unexpected output %h, none expected", out_data2);
      end else begin
        if (out_data2 !== q2[0]) begin
          errors++;
          $display("FAIL out_data2: got %h expected %h", out_data2, q2[0]);
        end
        if (out_ready2) void'(q2.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_default();
    rom1[0] = 32'h1100_000A;  // ADDI r1,10
    rom1[1] = 32'h1100_000D;  // ADDI r1,13
    rom1[2] = 32'h2120_0000;  // ADD  r1,r2
    for (int i = 3; i < 7; i++) rom1[i] = 32'h0000_0000;
    rom1[7] = 32'hF100_0000;  // OUT  r1
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the number of edges after the start edge until out_valid is seen.
  task automatic wait_valid(input int glitch_at, output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == glitch_at);
      if (n == 6) begin
        check("rom_addr_mid", {29'd0, rom_addr}, 32'd3);
        check("busy_mid", {31'd0, busy}, 32'd1);
      end
    end
    start = 1'b0;
  endtask

  task automatic run(input int stall, input int glitch_at);
    int n;
    pulse_start();
    wait_valid(glitch_at, n);
    check("valid_latency", n, 32'd16);
    check("busy_out_wait", {31'd0, busy}, 32'd1);
    check("halted_out_wait", {31'd0, halted}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("valid_stall", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("halted_end", {31'd0, halted}, 32'd1);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("rom_addr_end", {29'd0, rom_addr}, 32'd7);
  endtask

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start2     = 1'b0;
    out_ready  = 1'b1;
    out_ready2 = 1'b1;
    load_default();
    rom2[0] = 32'h15FF_FFFF;                       // ADDI r5,0xFFFFFF
    for (int i = 1; i < 9; i++) rom2[i] = 32'h2550_0000;  // ADD r5,r5 x8
    rom2[9]  = 32'h1500_00FF;                      // ADDI r5,0xFF -> 0xFFFFFFFF
    rom2[10] = 32'hF500_0000;                      // OUT r5
    rom2[11] = 32'h1500_0001;                      // ADDI r5,1 -> wraps to 0
    rom2[12] = 32'hF500_0000;                      // OUT r5
    for (int i = 13; i < 16; i++) rom2[i] = 32'h0000_0000;

    #2;
    check("rst_rom_addr", {29'd0, rom_addr}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Default program, consumer always ready.
    q.push_back(32'd23);
    run(0, -1);

    // Consumer stalls five cycles after out_valid rises.
    out_ready = 1'b0;
    q.push_back(32'd23);
    run(5, -1);

    // Unknown opcode 0101 at address 3 must behave as NOP.
    rom1[3] = 32'h5100_0005;
    q.push_back(32'd23);
    run(0, -1);
    load_default();

    // Doubling of 0x1FFFFFE through ADD r3,r3.
    rom1[0] = 32'h13FF_FFFF;
    rom1[1] = 32'h13FF_FFFF;
    rom1[2] = 32'h2330_0000;
    rom1[7] = 32'hF300_0000;
    q.push_back(32'h03FF_FFFC);
    run(0, -1);
    load_default();

    // Asynchronous reset in the middle of the OUT handshake.
    out_ready = 1'b0;
    q.push_back(32'd23);
    pulse_start();
    wait_valid(-1, n);
    check("rst_test_latency", n, 32'd16);
    check("reg_r1_before_rst", dut.regs[1], 32'd23);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rom_addr", {29'd0, rom_addr}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_reg_r1", dut.regs[1], 32'd0);
    q.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    q.push_back(32'd23);
    run(0, -1);

    // Restart from DONE, with a start pulse while busy that must be ignored.
    q.push_back(32'd23);
    run(0, 5);

    // 16-entry instance: 0xFFFFFFFF, then ADDI wraps it to zero.
    q2.push_back(32'hFFFF_FFFF);
    q2.push_back(32'h0000_0000);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    n = 0;
    while (!halted2 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("dut2_halted", {31'd0, halted2}, 32'd1);
    check("dut2_cycles", n, 32'd34);

    repeat (2) @(posedge clk);
    #1;
    check("q_drained", q.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_sequencer.md
# rom_sequencer

Instruction sequencer for the 8-entry, 32-bit program ROM. It drives the ROM address and latches each instruction. It executes the instruction against a local 16×32 register file and hands OUT results to a downstream consumer over a valid/ready handshake. It sits between the program ROM and the board-level output logic, and is the only block that addresses the ROM.

## Interface

Parameters:
- ADDR_W, 3, ROM address width; program length is 2^ADDR_W.
- DATA_W, 32, register and instruction width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- rom_addr  output  ADDR_W  ROM address; equals pc.
- rom_data  input  DATA_W  ROM instruction; combinational from rom_addr, valid in the same cycle.
- out_data  output  DATA_W  value of the OUT operand register.
- out_valid  output  1  out_data valid; held until accepted.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in FETCH, EXEC and OUT_WAIT.
- halted  output  1  high in DONE.

## Operation

Instruction fields:
- op = [31:28]
- rd = [27:24]
- rs = [23:20]
- imm = [23:0], zero-extended to 32 bits

Opcodes:
- 0000 NOP: no state change besides pc.
- 0001 ADDI: rd ← rd + imm.
- 0010 ADD: rd ← rd + rs. Both operands are read before the write, so rd==rs doubles the register.
- 1111 OUT: out_data ← rd, then wait for the handshake.
- Any other opcode: executes as NOP.
- All arithmetic is modulo 2^32; carry is discarded.

States:
- IDLE: start=1 → clear all 16 registers, pc←0, go to FETCH.
- FETCH: ir ← rom_data (rom_addr=pc), go to EXEC.
- EXEC for non-OUT: perform the write. If pc==7, go to DONE with pc held at 7. Otherwise pc←pc+1 and go to FETCH.
- EXEC for OUT: out_data ← reg[rd], out_valid←1, go to OUT_WAIT.
- OUT_WAIT: out_valid=1, out_data stable.
  - On out_valid & out_ready: out_valid←0, then advance exactly as for EXEC (pc==7 → DONE, else pc+1 → FETCH).
  - out_ready low: stay in OUT_WAIT indefinitely.
- DONE: halted=1. start=1 → same action as in IDLE (registers cleared, pc←0, FETCH).

Boundary conditions:
- pc never wraps. Address 7 is always the last instruction executed.
- start while busy is ignored.
- out_ready while out_valid=0 is ignored.
- Asynchronous reset in any state, including mid-handshake: immediately force IDLE, drop out_valid, reset all values to the list below.

Reset values:
- state=IDLE, pc=0, rom_addr=0.
- out_data=0, out_valid=0, busy=0, halted=0.
- All registers and ir = 0.

## Timing

- Non-OUT instruction: 2 cycles (FETCH and EXEC).
- OUT instruction: 2 cycles plus the number of OUT_WAIT cycles, minimum 1 OUT_WAIT cycle.
- Start edge E0 (start sampled): FETCH of pc k occurs at edge 2k+1, EXEC at edge 2k+2, assuming no OUT stalls.
- Register writes are visible to the next instruction's EXEC. No hazards, because there is no pipelining.
- out_valid rises on the edge that completes EXEC of the OUT. It falls on the edge where out_ready=1 is sampled.
- halted rises on the edge that leaves the pc=7 instruction.
- Everything is registered. No combinational path from out_ready to any output.

## Test plan

- Default program: ADDI r1,10 at 0; ADDI r1,13 at 1; ADD r1,r2 at 2; NOPs at 3–6; OUT r1 at 7. Pulse start, out_ready=1 → out_valid high after edge 16 with out_data=23; out_valid low and halted=1 after edge 17.
- Same program with out_ready held low for 5 cycles after out_valid rises → out_valid and out_data=23 stable throughout. Acceptance on the 6th cycle; halted=1 on the following edge.
- ADDI r3,0xFFFFFF twice, then ADD r3,r3, then OUT r3 → out_data = 0x3FFFFFC (doubling, no overflow). ADDI on 0xFFFFFFFF + 1 → 0 (modulo wrap).
- Unknown opcode 0101 at address 3 → register contents are identical to the NOP case and the cycle count is unchanged.
- Reset asserted during OUT_WAIT → out_valid=0, busy=0, pc=0, and registers read 0 immediately (asynchronous). A new start re-runs the program and produces 23 again.
- start pulsed in DONE → registers cleared, program re-executes, out_data=23. A start pulse during execution does not alter pc or timing.
